// File: rtl/input_capture_pkg.sv
// Shared definitions for the multi-channel input-capture unit: edge-select
// encodings, synchroniser depth floor and the edge-match helper.
package input_capture_pkg;

    typedef enum logic [1:0] {
        MODO_OFF  = 2'b00,
        MODO_RISE = 2'b01,
        MODO_FALL = 2'b10,
        MODO_BOTH = 2'b11
    } modo_e;

    localparam int MIN_SYNC_STAGES = 2;

    // True when the transition prevLevel -> curLevel matches the selected edge type.
    function automatic logic edgeMatch(input logic [1:0] modo,
                                       input logic       prevLevel,
                                       input logic       curLevel);
        logic hit;
        case (modo)
            MODO_OFF:  hit = 1'b0;
            MODO_RISE: hit = ~prevLevel & curLevel;
            MODO_FALL: hit = prevLevel & ~curLevel;
            MODO_BOTH: hit = prevLevel ^ curLevel;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/input_capture_channel.sv
// One capture channel: synchroniser, optional glitch filter (enabled by
// INPUT_CAPTURE_GLITCH_FILTER_EN), edge detect and capture/flag/overrun state.
module input_capture_channel
    import input_capture_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iEstimulo,
    input  logic [WIDTH-1:0] ivCuenta,
    input  logic [1:0]       ivModo,
    input  logic             iAck,
    output logic [WIDTH-1:0] ovCaptura,
    output logic             oCapturaFlag,
    output logic             oOverrun
);

    // Shallower chains are not metastability-safe, so depth is floored.
    localparam int SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [SYNC_N-1:0] syncChain_r;
    logic              syncLevel_s;
    logic              level_s;
    logic              prevLevel_r;
    logic              event_s;
    logic [WIDTH-1:0]  capture_r;
    logic              flag_r;
    logic              overrun_r;

    assign syncLevel_s = syncChain_r[SYNC_N-1];

    // Stimulus synchroniser chain.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            syncChain_r <= '0;
        end else begin
            syncChain_r <= {syncChain_r[SYNC_N-2:0], iEstimulo};
        end
    end

`ifdef INPUT_CAPTURE_GLITCH_FILTER_EN
    localparam int                FILT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

    logic [FILT_W-1:0] filtCnt_r;
    logic              filtLevel_r;

    // Filtered level flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            filtCnt_r   <= '0;
            filtLevel_r <= 1'b0;
        end else if (syncLevel_s != filtLevel_r) begin
            if (filtCnt_r == FILT_LAST) begin
                filtCnt_r   <= '0;
                filtLevel_r <= syncLevel_s;
            end else begin
                filtCnt_r   <= filtCnt_r + FILT_W'(1);
            end
        end else begin
            filtCnt_r <= '0;
        end
    end

    assign level_s = filtLevel_r;
`else
    assign level_s = syncLevel_s;
`endif

    // Previous-level register for edge detection.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            prevLevel_r <= 1'b0;
        end else begin
            prevLevel_r <= level_s;
        end
    end

    // Mode is applied combinationally so a change acts on the current edge.
    always_comb begin
        event_s = edgeMatch(ivModo, prevLevel_r, level_s);
    end

    // Capture, flag and overrun update in priority order.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            capture_r <= '0;
            flag_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else if (event_s && (!flag_r || iAck)) begin
            capture_r <= ivCuenta;
            flag_r    <= 1'b1;
        end else if (event_s) begin
            overrun_r <= 1'b1;
        end else if (iAck) begin
            flag_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            capture_r <= capture_r;
        end
    end

    assign ovCaptura    = capture_r;
    assign oCapturaFlag = flag_r;
    assign oOverrun     = overrun_r;

endmodule

// File: rtl/input_capture_mc.sv
// Multi-channel input capture on a shared count bus; glitch filter selected by
// INPUT_CAPTURE_GLITCH_FILTER_EN.
module input_capture_mc
    import input_capture_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic                      iClk,
    input  logic                      iReset,
    input  logic [CHANNELS-1:0]       ivEstimulo,
    input  logic [WIDTH-1:0]          ivCuenta,
    input  logic [2*CHANNELS-1:0]     ivModo,
    input  logic [CHANNELS-1:0]       ivAck,
    output logic [CHANNELS*WIDTH-1:0] ovCaptura,
    output logic [CHANNELS-1:0]       ovCapturaFlag,
    output logic [CHANNELS-1:0]       ovOverrun
);

    for (genvar n = 0; n < CHANNELS; n++) begin : gCanal
        input_capture_channel #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) uCanal (
            .iClk         (iClk),
            .iReset       (iReset),
            .iEstimulo    (ivEstimulo[n]),
            .ivCuenta     (ivCuenta),
            .ivModo       (ivModo[2*n +: 2]),
            .iAck         (ivAck[n]),
            .ovCaptura    (ovCaptura[WIDTH*n +: WIDTH]),
            .oCapturaFlag (ovCapturaFlag[n]),
            .oOverrun     (ovOverrun[n])
        );
    end

endmodule

// File: tb/tb_input_capture_mc.sv
// Bench for input_capture_mc: directed vector table, randomized run against a
// sample-history reference model, and glitch-filter sequences when enabled.
module tb_input_capture_mc;

    localparam int W = 8;
    localparam int C = 4;
    localparam int S = 2;
    localparam int FL = 3;

    logic             iClk = 1'b0;
    logic             iReset;
    logic [C-1:0]     ivEstimulo;
    logic [W-1:0]     ivCuenta;
    logic [2*C-1:0]   ivModo;
    logic [C-1:0]     ivAck;
    logic [C*W-1:0]   ovCaptura;
    logic [C-1:0]     ovCapturaFlag;
    logic [C-1:0]     ovOverrun;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    input_capture_mc #(.WIDTH(W), .CHANNELS(C), .SYNC_STAGES(S), .FILTER_LEN(FL)) dut (
        .iClk(iClk), .iReset(iReset), .ivEstimulo(ivEstimulo), .ivCuenta(ivCuenta),
        .ivModo(ivModo), .ivAck(ivAck), .ovCaptura(ovCaptura),
        .ovCapturaFlag(ovCapturaFlag), .ovOverrun(ovOverrun)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  stim;
        logic [7:0]  cuenta;
        logic [7:0]  modo;
        logic [3:0]  ack;
        logic [3:0]  eFlag;
        logic [3:0]  eOvr;
        logic [31:0] eCap;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] stim, input logic [7:0] cuenta,
                                input logic [7:0] modo, input logic [3:0] ack, input logic [3:0] eFlag,
                                input logic [3:0] eOvr, input logic [31:0] eCap);
        vec_t v;
        v.rst = rst; v.stim = stim; v.cuenta = cuenta; v.modo = modo; v.ack = ack;
        v.eFlag = eFlag; v.eOvr = eOvr; v.eCap = eCap;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] stim, input logic [7:0] cuenta,
                         input logic [7:0] modo, input logic [3:0] ack);
        iReset = rst; ivEstimulo = stim; ivCuenta = cuenta; ivModo = modo; ivAck = ack;
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [3:0] eFlag, input logic [3:0] eOvr,
                            input logic [31:0] eCap);
        checkVal({tag, ".flag"}, 32'(ovCapturaFlag), 32'(eFlag));
        checkVal({tag, ".ovr"}, 32'(ovOverrun), 32'(eOvr));
        checkVal({tag, ".cap"}, ovCaptura, eCap);
    endtask

`ifndef INPUT_CAPTURE_GLITCH_FILTER_EN
    // Reference model: sampled stimulus history; q[i] = sample taken i+1 edges ago.
    logic [C-1:0] q[$];
    logic [W-1:0] mCap[C];
    logic [C-1:0] mFlag, mOvr;

    task automatic modelEdge(input logic rst, input logic [C-1:0] stim, input logic [W-1:0] cuenta,
                             input logic [2*C-1:0] modo, input logic [C-1:0] ack);
        if (rst) begin
            for (int c = 0; c < C; c++) mCap[c] = '0;
            mFlag = '0; mOvr = '0;
            q = {};
            for (int i = 0; i <= S; i++) q.push_back('0);
        end else begin
            for (int c = 0; c < C; c++) begin
                logic cur, old, ev;
                logic [1:0] m;
                cur = q[S-1][c];
                old = q[S][c];
                m = modo[2*c +: 2];
                ev = (m == 2'b01 && !old && cur) || (m == 2'b10 && old && !cur) ||
                     (m == 2'b11 && old != cur);
                if (ev && (!mFlag[c] || ack[c])) begin
                    mCap[c] = cuenta; mFlag[c] = 1'b1;
                end else if (ev) begin
                    mOvr[c] = 1'b1;
                end else if (ack[c]) begin
                    mFlag[c] = 1'b0; mOvr[c] = 1'b0;
                end
            end
            q.push_front(stim);
            void'(q.pop_back());
        end
    endtask
`endif

    initial begin
        drive(1'b1, 4'h0, 8'h00, 8'h00, 4'h0);

`ifndef INPUT_CAPTURE_GLITCH_FILTER_EN
        // rst, stim, cuenta, modo, ack, expected flag, overrun, capture
        tbl.push_back(mk(1'b1, 4'h0, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 32'h0000_0000));
        tbl.push_back(mk(1'b0, 4'h0, 8'h37, 8'h01, 4'h0, 4'h0, 4'h0, 32'h0000_0000));
        tbl.push_back(mk(1'b0, 4'h1, 8'h37, 8'h01, 4'h0, 4'h0, 4'h0, 32'h0000_0000));
        tbl.push_back(mk(1'b0, 4'h1, 8'h37, 8'h01, 4'h0, 4'h0, 4'h0, 32'h0000_0000));
        tbl.push_back(mk(1'b0, 4'h1, 8'h37, 8'h01, 4'h0, 4'h1, 4'h0, 32'h0000_0037));
        tbl.push_back(mk(1'b0, 4'h3, 8'h50, 8'h09, 4'h0, 4'h1, 4'h0, 32'h0000_0037));
        tbl.push_back(mk(1'b0, 4'h3, 8'h50, 8'h09, 4'h0, 4'h1, 4'h0, 32'h0000_0037));
        tbl.push_back(mk(1'b0, 4'h3, 8'h50, 8'h09, 4'h0, 4'h1, 4'h0, 32'h0000_0037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h11, 8'h09, 4'h0, 4'h1, 4'h0, 32'h0000_0037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h22, 8'h09, 4'h0, 4'h1, 4'h0, 32'h0000_0037));
        tbl.push_back(mk(1'b0, 4'h1, 8'hA0, 8'h09, 4'h0, 4'h3, 4'h0, 32'h0000_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h00, 8'h09, 4'h2, 4'h1, 4'h0, 32'h0000_A037));
        tbl.push_back(mk(1'b0, 4'h5, 8'h00, 8'h39, 4'h0, 4'h1, 4'h0, 32'h0000_A037));
        tbl.push_back(mk(1'b0, 4'h5, 8'h00, 8'h39, 4'h0, 4'h1, 4'h0, 32'h0000_A037));
        tbl.push_back(mk(1'b0, 4'h5, 8'h10, 8'h39, 4'h0, 4'h5, 4'h0, 32'h0010_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h00, 8'h39, 4'h0, 4'h5, 4'h0, 32'h0010_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h00, 8'h39, 4'h0, 4'h5, 4'h0, 32'h0010_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h20, 8'h39, 4'h0, 4'h5, 4'h4, 32'h0010_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h00, 8'h39, 4'h4, 4'h1, 4'h0, 32'h0010_A037));
        tbl.push_back(mk(1'b0, 4'h9, 8'h00, 8'hF9, 4'h0, 4'h1, 4'h0, 32'h0010_A037));
        tbl.push_back(mk(1'b0, 4'h9, 8'h00, 8'hF9, 4'h0, 4'h1, 4'h0, 32'h0010_A037));
        tbl.push_back(mk(1'b0, 4'h9, 8'h05, 8'hF9, 4'h0, 4'h9, 4'h0, 32'h0510_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h00, 8'hF9, 4'h0, 4'h9, 4'h0, 32'h0510_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h00, 8'hF9, 4'h0, 4'h9, 4'h0, 32'h0510_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h44, 8'hF9, 4'h8, 4'h9, 4'h0, 32'h4410_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h00, 8'hF8, 4'h9, 4'h0, 4'h0, 32'h4410_A037));
        for (int i = 0; i < 9; i++) begin
            logic [3:0] st;
            st = (i >= 3 && i < 6) ? 4'h1 : 4'h0;
            tbl.push_back(mk(1'b0, st, 8'h77, 8'hF8, 4'h0, 4'h0, 4'h0, 32'h4410_A037));
        end
        tbl.push_back(mk(1'b0, 4'h1, 8'h66, 8'hF9, 4'h0, 4'h0, 4'h0, 32'h4410_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h66, 8'hF9, 4'h0, 4'h0, 4'h0, 32'h4410_A037));
        tbl.push_back(mk(1'b0, 4'h1, 8'h99, 8'hF9, 4'h0, 4'h1, 4'h0, 32'h4410_A099));
        tbl.push_back(mk(1'b1, 4'h1, 8'h12, 8'h01, 4'h0, 4'h0, 4'h0, 32'h0000_0000));
        tbl.push_back(mk(1'b1, 4'h1, 8'h12, 8'h01, 4'h0, 4'h0, 4'h0, 32'h0000_0000));
        tbl.push_back(mk(1'b0, 4'h1, 8'h00, 8'h01, 4'h0, 4'h0, 4'h0, 32'h0000_0000));
        tbl.push_back(mk(1'b0, 4'h1, 8'h00, 8'h01, 4'h0, 4'h0, 4'h0, 32'h0000_0000));
        tbl.push_back(mk(1'b0, 4'h1, 8'h5A, 8'h01, 4'h0, 4'h1, 4'h0, 32'h0000_005A));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stim, tbl[i].cuenta, tbl[i].modo, tbl[i].ack);
            step();
            checkAll($sformatf("tbl[%0d]", i), tbl[i].eFlag, tbl[i].eOvr, tbl[i].eCap);
        end

        begin
            logic [C-1:0]   stim = '0;
            logic [2*C-1:0] modo = 8'hFF;
            for (int n = 0; n < 600; n++) begin
                logic rst;
                logic [C-1:0] ack;
                logic [W-1:0] cuenta;
                logic [31:0] eCap;
                rst = (n == 0) || ($urandom_range(99) == 0);
                stim = stim ^ (4'($urandom) & 4'($urandom));
                if ($urandom_range(15) == 0) modo = 8'($urandom);
                ack = 4'($urandom) & 4'($urandom) & 4'($urandom);
                cuenta = 8'($urandom);
                drive(rst, stim, cuenta, modo, ack);
                modelEdge(rst, stim, cuenta, modo, ack);
                step();
                for (int c = 0; c < C; c++) eCap[W*c +: W] = mCap[c];
                checkAll($sformatf("rand[%0d]", n), mFlag, mOvr, eCap);
            end
        end
`else
        begin
            logic [31:0] held;
            drive(1'b1, 4'h0, 8'h00, 8'h01, 4'h0);
            step();
            checkAll("filt.reset", 4'h0, 4'h0, 32'h0);
            for (int j = 0; j < 14; j++) begin
                drive(1'b0, (j < 2) ? 4'h1 : 4'h0, 8'(8'h20 + j), 8'h01, 4'h0);
                step();
                checkVal($sformatf("filt.short[%0d].flag", j), 32'(ovCapturaFlag), 32'h0);
            end
            for (int j = 0; j < 10; j++) begin
                drive(1'b0, (j < 5) ? 4'h1 : 4'h0, 8'(8'h40 + j), 8'h01, 4'h0);
                step();
                checkAll($sformatf("filt.long[%0d]", j), (j >= 5) ? 4'h1 : 4'h0, 4'h0,
                         (j >= 5) ? 32'h45 : 32'h0);
            end
            held = 32'h45;
            for (int j = 0; j < 3; j++) begin
                drive((j == 2), 4'h1, 8'h66, 8'h01, 4'h0);
                step();
                if (j == 2) checkAll("filt.midreset", 4'h0, 4'h0, 32'h0);
                else        checkAll($sformatf("filt.prereset[%0d]", j), 4'h1, 4'h0, held);
            end
            for (int j = 0; j < 8; j++) begin
                drive(1'b0, 4'h0, 8'h77, 8'h01, 4'h0);
                step();
                checkAll($sformatf("filt.post[%0d]", j), 4'h0, 4'h0, 32'h0);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_capture_mc.md
Name: input_capture_mc

Overview:
Multi-channel, parametrised input-capture unit driven by a shared free-running count bus (8-bit counter).
- Each channel synchronises an external stimulus, detects the edge type selected for it, latches the current count and raises a flag.
- Each flag stays set until software acknowledges it.
- Adds per-channel edge selection, overrun reporting and an optional glitch filter. Sits between the counter and the register/bus interface.

Parameters:
WIDTH, 8, width of count bus and of each capture register
CHANNELS, 4, number of independent capture channels
SYNC_STAGES, 2, flops in each stimulus synchroniser (minimum 2)
FILTER_LEN, 3, consecutive stable samples required by the glitch filter (used only with the macro below)

Ports:
iClk  in  1  clock
iReset  in  1  synchronous, active-high reset; clock iClk
ivEstimulo  in  CHANNELS  asynchronous stimulus, one bit per channel
ivCuenta  in  WIDTH  current counter value
ivModo  in  2*CHANNELS  edge select, channel n = bits [2n+1:2n]: 00 off, 01 rising, 10 falling, 11 both
ivAck  in  CHANNELS  software acknowledge, one-cycle pulse per channel
ovCaptura  out  CHANNELS*WIDTH  captured counts, channel n = bits [WIDTH*(n+1)-1:WIDTH*n]
ovCapturaFlag  out  CHANNELS  capture-valid flag per channel
ovOverrun  out  CHANNELS  event lost while flag was set

Behaviour:
- Reset: ovCaptura, ovCapturaFlag, ovOverrun, synchroniser chains and previous-level registers all go to 0. Reset has priority over every other input. A stimulus held high through reset is reported as a rising edge once reset is released.
- Synchroniser: SYNC_STAGES flops per channel. The previous-level register samples the last stage every cycle.
- Event condition (combinational, on the synchronised level vs the previous level):
  - mode 01: 0->1
  - mode 10: 1->0
  - mode 11: either transition
  - mode 00: never
- Latency: stimulus first sampled high at edge k -> flag = 1 and ovCaptura = ivCuenta value at edge k+SYNC_STAGES, both registered.
- Per-channel update at each edge, in priority order:
  1. event and (flag = 0 or ack): capture <= ivCuenta, flag <= 1. An ack in the same cycle is consumed and overrun is unchanged.
  2. event and flag = 1 and no ack: capture held, flag held, overrun <= 1.
  3. ack, no event: flag <= 0, overrun <= 0, capture held.
  4. otherwise hold.
- Ack while flag = 0 and no event: no effect.
- Changing ivModo takes effect the same cycle. Existing flags, capture and overrun are kept. An edge arriving during the change uses the new mode.
- ivCuenta wrap-around has no special handling; the raw value is captured.
- Channels are fully independent; simultaneous events on several channels all capture the same ivCuenta.

Optional Feature:
INPUT_CAPTURE_GLITCH_FILTER_EN
- Defined: a per-channel saturating counter (clog2(FILTER_LEN+1) bits) sits after the synchroniser. The filtered level changes only after FILTER_LEN consecutive equal samples that differ from the current filtered level; a differing sample resets the counter. Edge detection uses the filtered level, so latency grows by FILTER_LEN edges. Pulses shorter than FILTER_LEN cycles are ignored. Filter state resets to 0.
- Undefined: no filter logic; edge detection uses the synchroniser output directly; FILTER_LEN is ignored.

Decomposition:
- Shared package input_capture_pkg:
  - mode encodings MODO_OFF = 2'b00, MODO_RISE = 2'b01, MODO_FALL = 2'b10, MODO_BOTH = 2'b11
  - MIN_SYNC_STAGES = 2
- One sub-module, input_capture_channel: synchroniser, optional filter, edge detect and capture/flag/overrun logic for a single channel. The top generates CHANNELS instances and concatenates their outputs.

Test Plan:
1. Reset then ch0 mode 01, ivCuenta = 8'h37, ivEstimulo[0] rises before edge 10 -> after edge 12: ovCapturaFlag[0] = 1, ovCaptura[7:0] = 8'h37; other channels 0.
2. ch1 mode 10, falling edge with ivCuenta = 8'hA0, then ack pulse -> capture 8'hA0, flag 1; the ack clears the flag; capture remains 8'hA0.
3. ch2 mode 11, edges at counts 8'h10 and 8'h20 with no ack -> capture stays 8'h10, flag 1, ovOverrun[2] = 1; a later ack clears both flag and overrun.
4. Event and ack in the same cycle on ch3 (flag already 1, previous capture 8'h05, count 8'h44) -> capture 8'h44, flag 1, overrun 0.
5. ch0 mode 00, several edges -> no flag and no capture change; switch to 01 -> the next rising edge captures normally.
6. With INPUT_CAPTURE_GLITCH_FILTER_EN and FILTER_LEN = 3: a 2-cycle high pulse produces no capture; a 5-cycle high pulse captures at edge k+SYNC_STAGES+3. Assert iReset mid-pulse -> all outputs 0 on the next edge.
